adc128s_spi_model: RTL and testbench
====================================

Name: adc128s_spi_model

Overview:
- Behavioural-synthesizable model of the 8-channel, 12-bit ADC128S SPI converter used on the Segway A2D bus.
- Serves four analog quantities supplied as 12-bit input buses: left load cell, right load cell, steering pot and battery.
- Acts as an SPI slave (mode 3) to the Segway A2D interface in the same clock domain.
- Pipelined like the real part: the channel addressed in frame N is returned in frame N+1.

Parameters:
- CH_LFT, 3'd0: channel number of ld_cell_lft.
- CH_RGHT, 3'd4: channel number of ld_cell_rght.
- CH_STEER, 3'd5: channel number of steerPot.
- CH_BATT, 3'd6: channel number of batt.

Ports:
- clk  in  1  system clock; every flop is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  active-low slave select from the master.
- SCLK  in  1  SPI clock from the master; idles high (mode 3).
- MOSI  in  1  serial command from the master.
- MISO  out  1  serial data to the master.
- ld_cell_lft  in  12  analog value of the left load cell.
- ld_cell_rght  in  12  analog value of the right load cell.
- steerPot  in  12  analog value of the steering pot.
- batt  in  12  analog value of the battery.

Behaviour:
- Edge detection:
  - SCLK and SS_n are registered each clk cycle.
  - sclk_rise = SCLK & ~SCLK_q; sclk_fall = ~SCLK & SCLK_q.
  - ss_fall = ~SS_n & SS_n_q; ss_rise = SS_n & ~SS_n_q.
- Reset (rst=1 at a clk edge):
  - cmd shift register = 0, tx shift register = 0, bit count = 0.
  - Channel pointer = 3'd0.
  - MISO = 1'bz.
- Frame length: 16 SCLK cycles, MSB first in both directions.
- Command format: bits[15:14]=00, bits[13:11]=channel, bits[10:0]=0. Only bits[13:11] are decoded; all other bits are ignored.
- On ss_fall:
  - Select the value for the current channel pointer (CH_LFT→ld_cell_lft, CH_RGHT→ld_cell_rght, CH_STEER→steerPot, CH_BATT→batt, any other channel→12'h000).
  - Load tx shift = {4'b0000, value}.
  - Clear bit count.
  - Drive MISO = tx[15] in the next cycle.
- While SS_n=0:
  - On sclk_rise: shift MOSI into the LSB of the cmd register and increment bit count.
  - On sclk_fall (except the first fall after SS_n low): shift tx left by 1 and drive MISO = the new tx[15].
  - Net effect: the master samples valid data on every SCLK rising edge.
- Frame completion:
  - When bit count reaches 16, on ss_rise: channel pointer ← cmd[13:11].
  - On ss_rise with bit count ≠ 16 (aborted frame): channel pointer unchanged.
  - MISO returns to 1'bz whenever SS_n=1.
- First frame after reset returns the channel-0 value (ld_cell_lft).
- Input sampling: analog inputs are sampled only at ss_fall. Input changes during a frame do not affect that frame.
- Back-to-back frames are supported with SS_n high for ≥2 clk cycles between them.
- Minimum SCLK half-period: 2 clk cycles.
- rst asserted mid-frame: the frame is aborted and reset values apply. The next frame starts only at a subsequent ss_fall.
- SCLK edges with SS_n=1 are ignored.

Decomposition:
- Shared package adc_pkg:
  - Default channel constants (0, 4, 5, 6).
  - FRAME_BITS=16.
  - Typedef chnl_t (logic [2:0]).
- One natural sub-module, spi_edge_det: registers SCLK and SS_n and outputs sclk_rise, sclk_fall, ss_fall, ss_rise.

Test Plan:
- Reset, then one frame with MOSI=16'h0000 and ld_cell_lft=12'h350 → MISO word = 16'h0350.
- Frame sending 16'h2000 (ch 4), then a second frame with ld_cell_rght=12'h340 → second MISO word = 16'h0340.
- Frame with ch 5 then ch 6 while steerPot=12'h800 and batt=12'hC00 → the ch-6 frame returns 16'h0800, the next frame returns 16'h0C00.
- Command ch 3 (16'h1800) followed by any frame → 16'h0000.
- Abort a ch-6 frame after 8 bits by raising SS_n → the next frame still returns the previously addressed channel.
- Assert rst mid-frame → MISO=z.
- Frame with SS_n=1 and SCLK toggling → no change to the channel pointer and MISO stays z.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC128S SPI converter model.
package adc_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_BITS = 12;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef logic [2:0] chnl_t;
  typedef logic [SAMPLE_BITS-1:0] sample_t;
  typedef logic [FRAME_BITS-1:0] frame_t;
  typedef logic [CNT_W-1:0] bit_cnt_t;

  // Default channel map used on the Segway A2D bus.
  localparam chnl_t CH_LFT_DEF = 3'd0;
  localparam chnl_t CH_RGHT_DEF = 3'd4;
  localparam chnl_t CH_STEER_DEF = 3'd5;
  localparam chnl_t CH_BATT_DEF = 3'd6;

  // LEAD covers the gap between SS_n falling and the first SCLK fall, which must not shift.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT
  } spi_state_t;

endpackage

// File: rtl/spi_edge_det.sv
// Registers SCLK and SS_n once in the clk domain and flags their edges.
module spi_edge_det (
  input  logic clk,
  input  logic SCLK,
  input  logic SS_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise
);

  logic sclk_q;
  logic ss_n_q;

  // NOTE: these flops only track the pins, so they take no reset; resetting them
  // to an idle level would fake an SS_n edge when rst releases with SS_n held low.
  always_ff @(posedge clk) begin
    sclk_q <= SCLK;
    ss_n_q <= SS_n;
  end

  assign sclk_rise = SCLK & ~sclk_q;
  assign sclk_fall = ~SCLK & sclk_q;
  assign ss_fall = ~SS_n & ss_n_q;
  assign ss_rise = SS_n & ~ss_n_q;

endmodule

// File: rtl/adc128s_spi_model.sv
// SPI-mode-3 slave model of the ADC128S; the channel addressed in one frame is returned in the next.
module adc128s_spi_model
  import adc_pkg::*;
#(
  parameter chnl_t CH_LFT = CH_LFT_DEF,
  parameter chnl_t CH_RGHT = CH_RGHT_DEF,
  parameter chnl_t CH_STEER = CH_STEER_DEF,
  parameter chnl_t CH_BATT = CH_BATT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;

  spi_edge_det u_edge_det (
    .clk       (clk),
    .SCLK      (SCLK),
    .SS_n      (SS_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  spi_state_t state;
  spi_state_t state_nxt;

  logic [13:0] cmd_shft;  // bits above 13 are never decoded, so they are not kept
  frame_t      tx_shft;
  bit_cnt_t    bit_cnt;
  chnl_t       chnl_ptr;
  sample_t     sel_val;

  logic load_en;
  logic sample_en;
  logic shift_en;
  logic commit_en;
  logic miso_en;

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ss_fall) state_nxt = ST_LEAD;
      ST_LEAD: begin
        if (ss_rise)        state_nxt = ST_IDLE;
        else if (sclk_fall) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: if (ss_rise) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_en = ss_fall;
    sample_en = (state != ST_IDLE) && !SS_n && sclk_rise;
    shift_en = (state == ST_SHIFT) && !SS_n && sclk_fall;
    commit_en = (state != ST_IDLE) && ss_rise && (bit_cnt == bit_cnt_t'(FRAME_BITS));
    miso_en = (state != ST_IDLE) && !SS_n;
  end

  // Priority chain so overlapping channel parameters still give a defined result.
  always_comb begin
    sel_val = '0;
    if      (chnl_ptr == CH_LFT)   sel_val = ld_cell_lft;
    else if (chnl_ptr == CH_RGHT)  sel_val = ld_cell_rght;
    else if (chnl_ptr == CH_STEER) sel_val = steerPot;
    else if (chnl_ptr == CH_BATT)  sel_val = batt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_shft <= '0;
      tx_shft <= '0;
      bit_cnt <= '0;
      chnl_ptr <= '0;
    end else begin
      if (load_en) begin
        tx_shft <= {{(FRAME_BITS - SAMPLE_BITS){1'b0}}, sel_val};
        bit_cnt <= '0;
      end else begin
        if (sample_en) begin
          cmd_shft <= {cmd_shft[12:0], MOSI};
          // Saturate so an over-long frame can never wrap back to a valid count.
          if (bit_cnt != '1) bit_cnt <= bit_cnt + bit_cnt_t'(1);
        end
        if (shift_en) tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
      end
      if (commit_en) chnl_ptr <= cmd_shft[13:11];
    end
  end

  assign MISO = miso_en ? tx_shft[FRAME_BITS-1] : 1'bz;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Scoreboard bench for adc128s_spi_model acting as a mode-3 SPI master.
module tb_adc128s_spi_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  wire         miso_w;
  logic [11:0] lft;
  logic [11:0] rght;
  logic [11:0] steer;
  logic [11:0] batt;

  // An undriven MISO reads as 1, so any stray drive of a 0 is visible.
  pullup (miso_w);

  always #5 clk = ~clk;

  adc128s_spi_model dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (miso_w),
    .ld_cell_lft  (lft),
    .ld_cell_rght (rght),
    .steerPot     (steer),
    .batt         (batt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [2:0]  model_ptr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [2:0] ch);
    case (ch)
      3'd0:    return {4'h0, lft};
      3'd4:    return {4'h0, rght};
      3'd5:    return {4'h0, steer};
      3'd6:    return {4'h0, batt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {15'd0, miso_w}, 16'h0001);
  endtask

  // Full frames are scored; short frames abort and leave the pointer alone.
  task automatic spi_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           input bit flip_mid);
    logic [15:0] rx;
    rx = '0;
    if (nbits == 16) exp_q.push_back(model_word(model_ptr));
    SS_n = 1'b0;
    wait_clk(3);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      wait_clk(3);
      rx = {rx[14:0], miso_w};
      if (flip_mid && i == 8) lft = ~lft;
      SCLK = 1'b1;
      wait_clk(3);
    end
    SS_n = 1'b1;
    wait_clk(3);
    check_idle({tag, "_idle"});
    if (nbits == 16) begin
      check(tag, rx, exp_q.pop_front());
      model_ptr = cmd[13:11];
    end
  endtask

  task automatic frame_with_rst();
    SS_n = 1'b0;
    wait_clk(3);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b0;
      wait_clk(3);
      SCLK = 1'b1;
      wait_clk(3);
    end
    rst = 1'b1;
    wait_clk(2);
    check_idle("rst_mid_frame");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b0;
      wait_clk(3);
      SCLK = 1'b1;
      wait_clk(3);
    end
    check_idle("after_rst_ss_low");
    SS_n = 1'b1;
    wait_clk(3);
    model_ptr = 3'd0;
  endtask

  initial begin
    rst = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    lft = 12'h350;
    rght = 12'h340;
    steer = 12'h800;
    batt = 12'hC00;
    model_ptr = 3'd0;
    wait_clk(4);
    check_idle("reset_miso");
    rst = 1'b0;
    wait_clk(2);

    spi_frame("lft_first", 16'h0000, 16, 1'b0);
    spi_frame("addr_rght", 16'h2000, 16, 1'b0);
    spi_frame("rght", 16'h2800, 16, 1'b0);
    spi_frame("steer", 16'h3000, 16, 1'b0);
    spi_frame("batt", 16'h1800, 16, 1'b0);
    spi_frame("ch3_zero", 16'h0000, 16, 1'b0);
    spi_frame("lft_hold", 16'h2800, 16, 1'b1);
    spi_frame("abort", 16'h3000, 8, 1'b0);
    spi_frame("after_abort", 16'h3000, 16, 1'b0);

    frame_with_rst();
    spi_frame("after_rst", 16'h3000, 16, 1'b0);

    MOSI = 1'b1;
    for (int i = 0; i < 6; i++) begin
      SCLK = ~SCLK;
      wait_clk(3);
      check_idle("sclk_ss_high");
    end
    SCLK = 1'b1;
    wait_clk(3);
    spi_frame("ptr_kept", 16'h0000, 16, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] cmd;
      lft = 12'($urandom);
      rght = 12'($urandom);
      steer = 12'($urandom);
      batt = 12'($urandom);
      cmd = 16'($urandom);
      spi_frame("rand", cmd, 16, 1'b0);
    end
    spi_frame("rand_last", 16'h0000, 16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
